// File: rtl/sprite_frontend_mc_if.sv
// Sprite front-end bus: line control, attribute RAM read port, drawer dispatch.
interface sprite_frontend_mc_if #(
  parameter int unsigned NUM_SPRITE = 32,
  parameter int unsigned NUM_DRAWER = 2
);
  localparam int unsigned AW = $clog2(NUM_SPRITE);

  logic                  start_row;
  logic [9:0]            next_vcount;
  logic [AW-1:0]         ra;
  logic [31:0]           rd_data;
  logic [NUM_DRAWER-1:0] drw_idle;
  logic [NUM_DRAWER-1:0] drw_req;
  logic [9:0]            col_base;
  logic                  flip;
  logic [7:0]            frame_id;
  logic [4:0]            row_off;
  logic                  fe_done;
  logic                  line_overflow;

  modport master (
    input  start_row, next_vcount, rd_data, drw_idle,
    output ra, drw_req, col_base, flip, frame_id, row_off, fe_done, line_overflow
  );

  modport slave (
    output start_row, next_vcount, rd_data, drw_idle,
    input  ra, drw_req, col_base, flip, frame_id, row_off, fe_done, line_overflow
  );
endinterface

// File: rtl/sprite_frontend_mc.sv
// Per-scanline sprite evaluator: scans the attribute table, queues hits and
// dispatches them to the lowest eligible idle line drawer.
module sprite_frontend_mc #(
  parameter int unsigned NUM_SPRITE    = 32,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned NUM_DRAWER    = 2,
  parameter int unsigned MAX_PER_LINE  = 16,
  parameter int unsigned VISIBLE_LINES = 480
) (
  input  logic                 clk,
  input  logic                 reset,
  sprite_frontend_mc_if.master bus
);
  localparam int unsigned AW = $clog2(NUM_SPRITE);
  localparam int unsigned FW = $clog2(FIFO_DEPTH);
  localparam int unsigned HW = $clog2(MAX_PER_LINE + 1);

  typedef struct packed {
    logic [9:0] col;
    logic       flip;
    logic [7:0] frame;
    logic [4:0] row;
  } hit_t;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         ra_q;
  logic                  eval_q;
  logic [9:0]            line_q;
  hit_t                  fifo_q [FIFO_DEPTH];
  logic [FW-1:0]         wp_q, rp_q;
  logic [FW:0]           cnt_q;
  logic [HW-1:0]         hcnt_q;
  logic                  ovf_q;
  logic [NUM_DRAWER-1:0] req_q;
  hit_t                  out_q;
  logic [1:0]            hold_q [NUM_DRAWER];
  logic                  fe_done_q;

  logic                  visible_c, room_c, issue_c, quiet_c;
  logic                  hit_c, push_c, pop_c, drop_c;
  logic [1:0]            size_c;
  logic [10:0]           h_c, y_c, v_c, d_c;
  hit_t                  hit_data_c;
  logic [NUM_DRAWER-1:0] elig_c, sel_c;
  logic                  hold_zero_c;

  assign visible_c = {1'b0, bus.next_vcount} < 11'(VISIBLE_LINES);

  // Hit test on the attribute word returned for last cycle's lookup.
  always_comb begin
    size_c       = bus.rd_data[28:27];
    h_c          = 11'd8 << size_c;
    y_c          = {2'b00, bus.rd_data[26:18]};
    v_c          = {1'b0, line_q};
    d_c          = v_c - y_c;
    hit_c        = eval_q && bus.rd_data[31] && (size_c != 2'd3) &&
                   (v_c >= y_c) && (v_c < y_c + h_c);
    hit_data_c.col   = bus.rd_data[17:8];
    hit_data_c.flip  = bus.rd_data[30];
    hit_data_c.frame = bus.rd_data[7:0];
    hit_data_c.row   = bus.rd_data[29] ? 5'(h_c - 11'd1 - d_c) : 5'(d_c);
    push_c       = hit_c && !bus.start_row && (hcnt_q < HW'(MAX_PER_LINE));
    drop_c       = hit_c && !bus.start_row && (hcnt_q >= HW'(MAX_PER_LINE));
  end

  // Drawer eligibility and lowest-index selection.
  always_comb begin
    logic found;
    found       = 1'b0;
    hold_zero_c = 1'b1;
    sel_c       = '0;
    for (int i = 0; i < NUM_DRAWER; i++) begin
      elig_c[i] = bus.drw_idle[i] && (hold_q[i] == 2'd0);
      if (hold_q[i] != 2'd0) hold_zero_c = 1'b0;
      if (elig_c[i] && !found) begin
        sel_c[i] = 1'b1;
        found    = 1'b1;
      end
    end
    pop_c = (cnt_q != '0) && (|elig_c) && !bus.start_row;
  end

  // FSM output/strobe decode.
  always_comb begin
    room_c  = ({1'b0, cnt_q} + (FW+2)'(eval_q)) < (FW+2)'(FIFO_DEPTH);
    issue_c = (state_q == S_SCAN) && !bus.start_row && room_c;
    quiet_c = !eval_q && (cnt_q == '0) && hold_zero_c && (&bus.drw_idle);
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    if (bus.start_row) begin
      state_d = visible_c ? S_SCAN : S_IDLE;
    end else begin
      case (state_q)
        S_SCAN:  if (issue_c && (ra_q == AW'(NUM_SPRITE - 1))) state_d = S_DRAIN;
        S_DRAIN: if (quiet_c) state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (push_c) fifo_q[wp_q] <= hit_data_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ra_q      <= '0;
      eval_q    <= 1'b0;
      line_q    <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      ovf_q     <= 1'b0;
      req_q     <= '0;
      out_q     <= '0;
      fe_done_q <= 1'b1;
      for (int i = 0; i < NUM_DRAWER; i++) hold_q[i] <= 2'd0;
    end else begin
      fe_done_q <= (state_d == S_IDLE);
      req_q     <= '0;
      // Drawers report idle one cycle late, so mask idle for two cycles.
      for (int i = 0; i < NUM_DRAWER; i++) begin
        if (pop_c && sel_c[i])     hold_q[i] <= 2'd2;
        else if (hold_q[i] != 2'd0) hold_q[i] <= hold_q[i] - 2'd1;
      end
      if (pop_c) begin
        req_q <= sel_c;
        out_q <= fifo_q[rp_q];
      end
      if (bus.start_row) begin
        line_q <= bus.next_vcount;
        ra_q   <= '0;
        eval_q <= 1'b0;
        wp_q   <= '0;
        rp_q   <= '0;
        cnt_q  <= '0;
        hcnt_q <= '0;
        ovf_q  <= 1'b0;
      end else begin
        eval_q <= issue_c;
        if (issue_c && (ra_q != AW'(NUM_SPRITE - 1))) ra_q <= ra_q + AW'(1);
        if (push_c) begin
          wp_q   <= wp_q + FW'(1);
          hcnt_q <= hcnt_q + HW'(1);
        end
        if (pop_c) rp_q <= rp_q + FW'(1);
        if (push_c && !pop_c)      cnt_q <= cnt_q + (FW+1)'(1);
        else if (!push_c && pop_c) cnt_q <= cnt_q - (FW+1)'(1);
        if (drop_c) ovf_q <= 1'b1;
      end
    end
  end

  assign bus.ra            = ra_q;
  assign bus.drw_req       = req_q;
  assign bus.col_base      = out_q.col;
  assign bus.flip          = out_q.flip;
  assign bus.frame_id      = out_q.frame;
  assign bus.row_off       = out_q.row;
  assign bus.fe_done       = fe_done_q;
  assign bus.line_overflow = ovf_q;
endmodule

// File: tb/tb_sprite_frontend_mc.sv
// Directed bench: two front-ends (A: FIFO 4 / limit 16, B: FIFO 8 / limit 4)
// share one attribute table and line stimulus; each has its own drawer model.
module tb_sprite_frontend_mc;
  logic        clk = 1'b0;
  logic        reset;
  logic        start_row;
  logic [9:0]  next_vcount;
  logic [31:0] mem [32];
  logic [31:0] rd_a, rd_b;
  logic [1:0]  pend_a, pend_b, idle_a, idle_b;
  int          cnt_a [2];
  int          cnt_b [2];
  int          dur;
  int          multi_a, multi_b;
  logic [31:0] log_a [$];
  logic [31:0] log_b [$];
  int          tests_run = 0;
  int          tests_failed = 0;

  always #5 clk = ~clk;

  sprite_frontend_mc_if #(.NUM_SPRITE(32), .NUM_DRAWER(2)) bus_a ();
  sprite_frontend_mc_if #(.NUM_SPRITE(32), .NUM_DRAWER(2)) bus_b ();

  sprite_frontend_mc #(.NUM_SPRITE(32), .FIFO_DEPTH(4), .NUM_DRAWER(2),
                       .MAX_PER_LINE(16), .VISIBLE_LINES(480))
    u_a (.clk(clk), .reset(reset), .bus(bus_a));
  sprite_frontend_mc #(.NUM_SPRITE(32), .FIFO_DEPTH(8), .NUM_DRAWER(2),
                       .MAX_PER_LINE(4), .VISIBLE_LINES(480))
    u_b (.clk(clk), .reset(reset), .bus(bus_b));

  assign bus_a.start_row   = start_row;
  assign bus_b.start_row   = start_row;
  assign bus_a.next_vcount = next_vcount;
  assign bus_b.next_vcount = next_vcount;
  assign bus_a.rd_data     = rd_a;
  assign bus_b.rd_data     = rd_b;
  assign bus_a.drw_idle    = idle_a;
  assign bus_b.drw_idle    = idle_b;

  always @(posedge clk) begin
    rd_a <= mem[bus_a.ra];
    rd_b <= mem[bus_b.ra];
  end

  // Drawers drop idle one cycle after seeing their start pulse.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      pend_a[i] <= bus_a.drw_req[i];
      pend_b[i] <= bus_b.drw_req[i];
      if (reset)          cnt_a[i] <= 0;
      else if (pend_a[i]) cnt_a[i] <= dur;
      else if (cnt_a[i] > 0) cnt_a[i] <= cnt_a[i] - 1;
      if (reset)          cnt_b[i] <= 0;
      else if (pend_b[i]) cnt_b[i] <= dur;
      else if (cnt_b[i] > 0) cnt_b[i] <= cnt_b[i] - 1;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      idle_a[i] = (cnt_a[i] == 0);
      idle_b[i] = (cnt_b[i] == 0);
    end
  end

  function automatic logic [31:0] ent(input logic [1:0] drw, input logic fl,
                                      input logic [4:0] row, input logic [7:0] fr,
                                      input logic [9:0] col);
    return {6'b0, drw, fl, row, fr, col};
  endfunction

  function automatic logic [31:0] mk(input logic hf, input logic vf, input logic [1:0] sz,
                                     input logic [8:0] y, input logic [9:0] x,
                                     input logic [7:0] fr);
    return {1'b1, hf, vf, sz, y, x, fr};
  endfunction

  function automatic logic [31:0] get_a(input int k);
    return (k < log_a.size()) ? log_a[k] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] get_b(input int k);
    return (k < log_b.size()) ? log_b[k] : 32'hFFFF_FFFF;
  endfunction

  always @(negedge clk) begin
    if (bus_a.drw_req != 2'b00) begin
      log_a.push_back(ent(bus_a.drw_req[1] ? 2'd1 : 2'd0, bus_a.flip, bus_a.row_off,
                          bus_a.frame_id, bus_a.col_base));
      if (bus_a.drw_req == 2'b11) multi_a++;
    end
    if (bus_b.drw_req != 2'b00) begin
      log_b.push_back(ent(bus_b.drw_req[1] ? 2'd1 : 2'd0, bus_b.flip, bus_b.row_off,
                          bus_b.frame_id, bus_b.col_base));
      if (bus_b.drw_req == 2'b11) multi_b++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 32'h1800_0000;
  endtask

  task automatic start_line(input logic [9:0] v);
    next_vcount = v;
    start_row   = 1'b1;
    @(posedge clk);
    #1;
    start_row = 1'b0;
    log_a.delete();
    log_b.delete();
    multi_a = 0;
    multi_b = 0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (bus_a.fe_done && bus_b.fe_done) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if (bus_a.ra !== 5'd0 || bus_a.drw_req !== 2'b00) begin
      tests_failed++; $display("FAIL reset_ra_req got ra=%0d req=%b exp 0/00", bus_a.ra, bus_a.drw_req);
    end
    tests_run++;
    if ({bus_a.col_base, bus_a.flip, bus_a.frame_id, bus_a.row_off} !== 24'd0) begin
      tests_failed++; $display("FAIL reset_payload got col=%0d fr=%0d row=%0d exp 0", bus_a.col_base, bus_a.frame_id, bus_a.row_off);
    end
    tests_run++;
    if (bus_a.fe_done !== 1'b1 || bus_b.fe_done !== 1'b1 || bus_a.line_overflow !== 1'b0) begin
      tests_failed++; $display("FAIL reset_flags got done=%b/%b ovf=%b exp 1/1/0", bus_a.fe_done, bus_b.fe_done, bus_a.line_overflow);
    end
  endtask

  task automatic test_blank();
    start_line(10'd500);
    tests_run++;
    if (bus_a.fe_done !== 1'b1) begin
      tests_failed++; $display("FAIL blank_done got %b exp 1", bus_a.fe_done);
    end
    tick(10);
    tests_run++;
    if (log_a.size() != 0 || bus_a.ra !== 5'd0) begin
      tests_failed++; $display("FAIL blank_quiet got reqs=%0d ra=%0d exp 0/0", log_a.size(), bus_a.ra);
    end
  endtask

  task automatic test_single();
    bit ok;
    clear_mem();
    mem[3] = mk(1'b0, 1'b0, 2'd1, 9'd100, 10'd40, 8'd7);
    start_line(10'd105);
    tests_run++;
    if (bus_a.fe_done !== 1'b0) begin
      tests_failed++; $display("FAIL single_busy got %b exp 0", bus_a.fe_done);
    end
    wait_done(ok);
    tests_run++;
    if (!ok || idle_a !== 2'b11) begin
      tests_failed++; $display("FAIL single_done got ok=%0d idle=%b exp 1/11", ok, idle_a);
    end
    tests_run++;
    if (log_a.size() != 1 || get_a(0) !== ent(2'd0, 1'b0, 5'd5, 8'd7, 10'd40)) begin
      tests_failed++; $display("FAIL single_disp got n=%0d e=%h exp 1/%h", log_a.size(), get_a(0), ent(2'd0, 1'b0, 5'd5, 8'd7, 10'd40));
    end
    tests_run++;
    if (bus_a.col_base !== 10'd40 || bus_a.frame_id !== 8'd7 || bus_a.row_off !== 5'd5) begin
      tests_failed++; $display("FAIL single_hold got col=%0d fr=%0d row=%0d exp 40/7/5", bus_a.col_base, bus_a.frame_id, bus_a.row_off);
    end
  endtask

  task automatic test_multi();
    bit ok;
    logic [31:0] e;
    clear_mem();
    for (int i = 0; i < 6; i++) mem[i] = mk(1'b0, 1'b0, 2'd0, 9'd48, 10'(20 + i), 8'(i));
    start_line(10'd50);
    wait_done(ok);
    tests_run++;
    if (!ok || log_a.size() != 6 || multi_a != 0) begin
      tests_failed++; $display("FAIL multi_count got ok=%0d n=%0d multi=%0d exp 1/6/0", ok, log_a.size(), multi_a);
    end
    for (int k = 0; k < 6; k++) begin
      e = ent(2'(k % 2), 1'b0, 5'd2, 8'(k), 10'(20 + k));
      tests_run++;
      if (get_a(k) !== e) begin
        tests_failed++; $display("FAIL multi_entry%0d got %h exp %h", k, get_a(k), e);
      end
    end
  endtask

  task automatic test_vflip();
    bit ok;
    logic [31:0] e0, e1;
    clear_mem();
    mem[0] = mk(1'b1, 1'b1, 2'd2, 9'd0, 10'd100, 8'd9);
    mem[1] = mk(1'b0, 1'b0, 2'd0, 9'd10, 10'd200, 8'd8);
    start_line(10'd3);
    wait_done(ok);
    e0 = ent(2'd0, 1'b1, 5'd28, 8'd9, 10'd100);
    tests_run++;
    if (!ok || log_a.size() != 1 || get_a(0) !== e0) begin
      tests_failed++; $display("FAIL vflip_l3 got n=%0d e=%h exp 1/%h", log_a.size(), get_a(0), e0);
    end
    start_line(10'd18);
    wait_done(ok);
    e0 = ent(2'd0, 1'b1, 5'd13, 8'd9, 10'd100);
    tests_run++;
    if (!ok || log_a.size() != 1 || get_a(0) !== e0) begin
      tests_failed++; $display("FAIL vflip_l18 got n=%0d e=%h exp 1/%h", log_a.size(), get_a(0), e0);
    end
    start_line(10'd17);
    wait_done(ok);
    e0 = ent(2'd0, 1'b1, 5'd14, 8'd9, 10'd100);
    e1 = ent(2'd1, 1'b0, 5'd7, 8'd8, 10'd200);
    tests_run++;
    if (!ok || log_a.size() != 2 || get_a(0) !== e0 || get_a(1) !== e1) begin
      tests_failed++; $display("FAIL vflip_l17 got n=%0d e=%h,%h exp 2/%h,%h", log_a.size(), get_a(0), get_a(1), e0, e1);
    end
    start_line(10'd32);
    wait_done(ok);
    tests_run++;
    if (!ok || log_a.size() != 0) begin
      tests_failed++; $display("FAIL vflip_l32 got ok=%0d n=%0d exp 1/0", ok, log_a.size());
    end
  endtask

  task automatic test_limit();
    bit ok;
    int idx [6] = '{2, 5, 7, 9, 11, 13};
    logic [31:0] e;
    clear_mem();
    for (int i = 0; i < 6; i++) mem[idx[i]] = mk(1'b0, 1'b0, 2'd0, 9'd60, 10'(100 + idx[i]), 8'(idx[i]));
    start_line(10'd60);
    wait_done(ok);
    tests_run++;
    if (!ok || log_b.size() != 4 || bus_b.line_overflow !== 1'b1) begin
      tests_failed++; $display("FAIL limit_b got ok=%0d n=%0d ovf=%b exp 1/4/1", ok, log_b.size(), bus_b.line_overflow);
    end
    for (int k = 0; k < 4; k++) begin
      e = ent(2'd0, 1'b0, 5'd0, 8'(idx[k]), 10'(100 + idx[k]));
      tests_run++;
      if ((get_b(k) & 32'h00FF_FFFF) !== e) begin
        tests_failed++; $display("FAIL limit_entry%0d got %h exp %h", k, get_b(k) & 32'h00FF_FFFF, e);
      end
    end
    tests_run++;
    if (log_a.size() != 6 || bus_a.line_overflow !== 1'b0) begin
      tests_failed++; $display("FAIL limit_a got n=%0d ovf=%b exp 6/0", log_a.size(), bus_a.line_overflow);
    end
    start_line(10'd500);
    tests_run++;
    if (bus_b.line_overflow !== 1'b0) begin
      tests_failed++; $display("FAIL limit_clear got %b exp 0", bus_b.line_overflow);
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [31:0] e;
    dur = 30;
    clear_mem();
    for (int i = 0; i < 20; i++) mem[i] = mk(1'b0, 1'b0, 2'd1, 9'd195, 10'(300 + i), 8'(i));
    mem[25] = mk(1'b0, 1'b0, 2'd0, 9'd300, 10'd500, 8'd25);
    start_line(10'd200);
    wait_done(ok);
    tests_run++;
    if (!ok || log_a.size() != 16 || multi_a != 0 || bus_a.line_overflow !== 1'b1) begin
      tests_failed++; $display("FAIL stall_count got ok=%0d n=%0d multi=%0d ovf=%b exp 1/16/0/1", ok, log_a.size(), multi_a, bus_a.line_overflow);
    end
    for (int k = 0; k < 16; k++) begin
      e = ent(2'd0, 1'b0, 5'd5, 8'(k), 10'(300 + k));
      tests_run++;
      if ((get_a(k) & 32'h00FF_FFFF) !== e) begin
        tests_failed++; $display("FAIL stall_entry%0d got %h exp %h", k, get_a(k) & 32'h00FF_FFFF, e);
      end
    end
    // Abort a stalled scan part-way through with a new line.
    start_line(10'd200);
    tick(20);
    tests_run++;
    if (bus_a.ra < 5'd4 || bus_a.ra > 5'd8) begin
      tests_failed++; $display("FAIL stall_ra got %0d exp 4..8", bus_a.ra);
    end
    start_line(10'd300);
    tests_run++;
    if (bus_a.ra !== 5'd0 || bus_a.fe_done !== 1'b0 || bus_a.line_overflow !== 1'b0) begin
      tests_failed++; $display("FAIL abort_restart got ra=%0d done=%b ovf=%b exp 0/0/0", bus_a.ra, bus_a.fe_done, bus_a.line_overflow);
    end
    wait_done(ok);
    e = ent(2'd0, 1'b0, 5'd0, 8'd25, 10'd500);
    tests_run++;
    if (!ok || log_a.size() != 1 || (get_a(0) & 32'h00FF_FFFF) !== e) begin
      tests_failed++; $display("FAIL abort_a got n=%0d e=%h exp 1/%h", log_a.size(), get_a(0), e);
    end
    tests_run++;
    if (log_b.size() != 1 || (get_b(0) & 32'h00FF_FFFF) !== e) begin
      tests_failed++; $display("FAIL abort_b got n=%0d e=%h exp 1/%h", log_b.size(), get_b(0), e);
    end
  endtask

  initial begin
    reset       = 1'b1;
    start_row   = 1'b0;
    next_vcount = 10'd0;
    dur         = 10;
    multi_a     = 0;
    multi_b     = 0;
    clear_mem();
    tick(3);
    reset = 1'b0;
    test_reset();
    tick(1);
    test_blank();
    test_single();
    test_multi();
    test_vflip();
    test_limit();
    test_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/sprite_frontend_mc.md
Name: sprite_frontend_mc

Overview:
Per-scanline sprite evaluator with multi-drawer dispatch. At each start_row it scans the sprite attribute table (1-cycle-latency RAM) for sprites covering next_vcount and queues hits in a parametrised FIFO. It dispatches queued hits to NUM_DRAWER independent line drawers, lowest idle index first. Over its predecessor it adds:
- per-sprite height (8/16/32)
- vertical flip
- a per-line hit limit with a sticky overflow flag

Parameters:
NUM_SPRITE, 32, attribute table entries (power of 2, >=4)
FIFO_DEPTH, 8, hit queue entries (power of 2, >=4)
NUM_DRAWER, 2, drawer channels (1..4)
MAX_PER_LINE, 16, max hits accepted per line (1..NUM_SPRITE)
VISIBLE_LINES, 480, rows at or beyond this are blank

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start_row  in  1  one-cycle pulse, begin evaluating line next_vcount
next_vcount  in  10  line to evaluate, sampled at start_row and held stable
ra  out  log2(NUM_SPRITE)  attribute RAM read address
rd_data  in  32  attribute word for ra of previous cycle: [31] en, [30] hflip, [29] vflip, [28:27] size (0=8, 1=16, 2=32, 3=disabled), [26:18] y, [17:8] x, [7:0] frame
drw_idle  in  NUM_DRAWER  1 = drawer i idle
drw_req  out  NUM_DRAWER  one-hot, one-cycle start pulse
col_base  out  10  x of dispatched sprite
flip  out  1  hflip of dispatched sprite
frame_id  out  8  frame of dispatched sprite
row_off  out  5  row within sprite, vflip applied
fe_done  out  1  1 = line complete / idle
line_overflow  out  1  sticky per line; a hit was dropped

Behaviour:
- Reset: ra=0, drw_req=0, col_base=0, flip=0, frame_id=0, row_off=0, fe_done=1, line_overflow=0, FIFO empty, hit count 0, hold-off counters 0.
- start_row (priority over all but reset) flushes FIFO, hit count, line_overflow and scan pointer.
  - next_vcount >= VISIBLE_LINES: fe_done=1 next cycle.
  - Otherwise fe_done=0 next cycle and scanning starts.
  - start_row mid-line aborts the old line; queued entries are discarded, and drawers already started finish on their own.
- Scan:
  - ra advances 0..NUM_SPRITE-1, one per cycle, only while (FIFO count + lookups in flight) < FIFO_DEPTH.
  - A lookup issued at cycle t is evaluated at t+1. Each index is evaluated exactly once, whatever the stalls.
- Hit: en=1, size!=3, h = 8<<size, y <= next_vcount < y+h, computed at 11 bits with no wrap.
  - d = next_vcount - y.
  - row_off = vflip ? h-1-d : d, zero-extended to 5 bits.
- Hit limit:
  - Hits 1..MAX_PER_LINE are enqueued in index order.
  - Later hits are dropped and set line_overflow; it holds until the next start_row or reset.
- Dispatch:
  - Drawer i is eligible if drw_idle[i]=1 and its hold-off counter is 0.
  - If the FIFO is non-empty and any drawer is eligible, pop the head, register the payload, and pulse drw_req for the lowest eligible i.
  - The payload is held until the next dispatch.
  - Each dispatch loads hold-off[i]=2: drw_idle[i] is ignored for the 2 cycles after the pulse, because drawers drop idle one cycle late.
  - At most one dispatch per cycle.
- Simultaneous enqueue and dequeue: count unchanged; pointers wrap modulo FIFO_DEPTH.
- Full FIFO: scanning stalls and no hit is lost.
- Empty FIFO: no dispatch.
- fe_done rises the cycle after all of the following hold:
  - all indices evaluated
  - FIFO empty
  - all hold-off counters 0
  - drw_idle all 1
- Once high, fe_done stays high until the next start_row on a visible line.

Test Plan:
- Reset, then start_row with next_vcount=500 -> fe_done=1 the next cycle, no drw_req, ra static.
- Sprite 3 = {en, size=1, y=100, x=40, frame=7}, line 105, all others disabled -> exactly one drw_req; col_base=40, frame_id=7, row_off=5; fe_done after the drawer returns idle.
- Sprites 0..5 hit line 50; NUM_DRAWER=2; drawers idle 10 cycles after each req -> dispatches alternate drawer 0/1 in index order, 6 total, never two at once, no entry lost.
- vflip=1 with size=2, y=0, line 3 -> row_off=28. size=0, y=10, line 18 -> no hit (row beyond height).
- MAX_PER_LINE=4, 6 hits -> 4 dispatches (indices lowest first), line_overflow=1. The next start_row clears it.
- 20 hits, FIFO_DEPTH=4, slow drawers -> scan stalls, FIFO count never exceeds 4, all 16 accepted hits dispatched. A start_row mid-scan flushes the queue and restarts at ra=0.
